// File: rtl/score_pkg.sv
// Shared constants and state type for the line-clear flash controller.
package score_pkg;

   localparam int unsigned MODE_RESTART = 0;
   localparam int unsigned MODE_EXTEND  = 1;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } flash_state_e;

endpackage

// File: rtl/hit_duration_lut.sv
// Flash duration for a line-clear count: D(n) = n*(n+2), saturated to the countdown width.
module hit_duration_lut #(
   parameter int unsigned LINE_W = 3,
   parameter int unsigned TIME_W = 6
) (
   input  logic [LINE_W-1:0] line_count_i,
   output logic [TIME_W-1:0] duration_o
);

   // Product is evaluated wide enough that it can never wrap before the saturation test.
   localparam int unsigned PROD_W = 2 * LINE_W + 2;
   localparam int unsigned CMP_W  = ((PROD_W > TIME_W) ? PROD_W : TIME_W) + 1;
   localparam logic [CMP_W-1:0] DUR_MAX = {{(CMP_W - TIME_W){1'b0}}, {TIME_W{1'b1}}};

   logic [CMP_W-1:0] n_ext;
   logic [CMP_W-1:0] prod;

   always_comb begin
      n_ext      = CMP_W'(line_count_i);
      prod       = n_ext * (n_ext + CMP_W'(2));
      duration_o = (prod > DUR_MAX) ? '1 : prod[TIME_W-1:0];
   end

endmodule

// File: rtl/hit_flash_ctrl.sv
// Line-clear flash window: countdown, combo counter, blink phase and end-of-window pulse.
module hit_flash_ctrl
   import score_pkg::*;
#(
   parameter int unsigned LINE_W    = 3,
   parameter int unsigned TIME_W    = 6,
   parameter int unsigned BLINK_DIV = 4,
   parameter int unsigned MODE      = MODE_RESTART
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hit,
   input  logic [LINE_W-1:0] lineCount,
   output logic              hitTime,
   output logic              blink,
   output logic [LINE_W-1:0] comboLevel,
   output logic [TIME_W-1:0] remaining,
   output logic              done
);

   localparam int unsigned DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);

   flash_state_e      state_q, state_d;
   logic [TIME_W-1:0] remaining_q, remaining_d;
   logic [LINE_W-1:0] combo_q, combo_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              hit_time_q, hit_time_d;
   logic              blink_q, blink_d;
   logic              done_q, done_d;
   logic              hit_valid;
   logic [TIME_W-1:0] dur;

   hit_duration_lut #(
      .LINE_W (LINE_W),
      .TIME_W (TIME_W)
   ) u_lut (
      .line_count_i (lineCount),
      .duration_o   (dur)
   );

   assign hit_valid = hit && (lineCount != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         combo_q     <= '0;
         div_q       <= '0;
         hit_time_q  <= 1'b0;
         blink_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         combo_q     <= combo_d;
         div_q       <= div_d;
         hit_time_q  <= hit_time_d;
         blink_q     <= blink_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      combo_d     = combo_q;
      div_d       = div_q;
      hit_time_d  = hit_time_q;
      blink_d     = blink_q;
      done_d      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (hit_valid) begin
               state_d     = ST_ACTIVE;
               remaining_d = dur;
               combo_d     = LINE_W'(1);
               div_d       = '0;
               hit_time_d  = 1'b1;
               blink_d     = 1'b1;
            end
         end

         ST_ACTIVE: begin
            // A retrigger wins over expiry and suppresses the decrement on its edge.
            if (hit_valid) begin
               if ((MODE == MODE_EXTEND) && (remaining_q > dur)) begin
                  remaining_d = remaining_q;
               end else begin
                  remaining_d = dur;
               end
               if (combo_q != '1) begin
                  combo_d = combo_q + LINE_W'(1);
               end
               div_d   = '0;
               blink_d = 1'b1;
            end else if (remaining_q == '0) begin
               state_d    = ST_IDLE;
               combo_d    = '0;
               div_d      = '0;
               hit_time_d = 1'b0;
               blink_d    = 1'b0;
               done_d     = 1'b1;
            end else begin
               remaining_d = remaining_q - TIME_W'(1);
               if (div_q == DIV_LAST) begin
                  div_d   = '0;
                  blink_d = ~blink_q;
               end else begin
                  div_d = div_q + DIV_W'(1);
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign hitTime    = hit_time_q;
   assign blink      = blink_q;
   assign comboLevel = combo_q;
   assign remaining  = remaining_q;
   assign done       = done_q;

endmodule

// File: tb/tb_hit_flash_ctrl.sv
// Bench for hit_flash_ctrl: vector table, directed corner sequences and random traffic vs a reference model.
module tb_hit_flash_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       hit = 1'b0;
   logic [2:0] lineCount = 3'd0;

   logic       ht0, bl0, dn0, ht1, bl1, dn1, ht2, bl2, dn2;
   logic [2:0] cl0, cl1, cl2;
   logic [5:0] rem0, rem1;
   logic [3:0] rem2;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   always #5 clk = ~clk;

   hit_flash_ctrl #(.LINE_W(3), .TIME_W(6), .BLINK_DIV(4), .MODE(0)) dut0 (
      .clk(clk), .rst(rst), .hit(hit), .lineCount(lineCount),
      .hitTime(ht0), .blink(bl0), .comboLevel(cl0), .remaining(rem0), .done(dn0));

   hit_flash_ctrl #(.LINE_W(3), .TIME_W(6), .BLINK_DIV(3), .MODE(1)) dut1 (
      .clk(clk), .rst(rst), .hit(hit), .lineCount(lineCount),
      .hitTime(ht1), .blink(bl1), .comboLevel(cl1), .remaining(rem1), .done(dn1));

   hit_flash_ctrl #(.LINE_W(3), .TIME_W(4), .BLINK_DIV(1), .MODE(0)) dut2 (
      .clk(clk), .rst(rst), .hit(hit), .lineCount(lineCount),
      .hitTime(ht2), .blink(bl2), .comboLevel(cl2), .remaining(rem2), .done(dn2));

   // Reference model: window length, hit count and cycles elapsed since the last hit.
   int M_MODE[3] = '{0, 1, 0};
   int M_TMAX[3] = '{63, 63, 15};
   int M_BD[3]   = '{4, 3, 1};
   int m_act[3], m_rem[3], m_combo[3], m_since[3], m_done[3];

   task automatic model_step(input logic r, input logic h, input int n);
      for (int i = 0; i < 3; i++) begin
         int d;
         d = n * (n + 2);
         if (d > M_TMAX[i]) d = M_TMAX[i];
         m_done[i] = 0;
         if (r) begin
            m_act[i] = 0; m_rem[i] = 0; m_combo[i] = 0; m_since[i] = 0;
         end else if (h && n != 0) begin
            if (m_act[i] == 0) begin
               m_rem[i]   = d;
               m_combo[i] = 1;
            end else begin
               m_rem[i] = (M_MODE[i] == 1 && m_rem[i] > d) ? m_rem[i] : d;
               if (m_combo[i] < 7) m_combo[i]++;
            end
            m_act[i]   = 1;
            m_since[i] = 0;
         end else if (m_act[i] != 0) begin
            if (m_rem[i] == 0) begin
               m_act[i] = 0; m_combo[i] = 0; m_since[i] = 0; m_done[i] = 1;
            end else begin
               m_rem[i]--;
               m_since[i]++;
            end
         end
      end
   endtask

   function automatic logic [12:0] pack(input logic ht, input logic bl, input logic [2:0] cl,
                                        input logic [6:0] rem, input logic dn);
      return {ht, bl, cl, rem, dn};
   endfunction

   function automatic logic [12:0] got(input int i);
      case (i)
         0:       return pack(ht0, bl0, cl0, 7'(rem0), dn0);
         1:       return pack(ht1, bl1, cl1, 7'(rem1), dn1);
         default: return pack(ht2, bl2, cl2, 7'(rem2), dn2);
      endcase
   endfunction

   function automatic logic [12:0] model_exp(input int i);
      logic b;
      b = (m_act[i] != 0) && (((m_since[i] / M_BD[i]) % 2) == 0);
      return pack(m_act[i] != 0, b, 3'(m_combo[i]), 7'(m_rem[i]), m_done[i] != 0);
   endfunction

   task automatic check(input string nm, input logic [12:0] actual, input logic [12:0] want);
      n_total++;
      if (actual === want) n_pass++;
      else $display("FAIL %s: got {ht,bl,combo,rem,done}=%b_%b_%0d_%0d_%b want %b_%b_%0d_%0d_%b",
                    nm, actual[12], actual[11], actual[10:8], actual[7:1], actual[0],
                    want[12], want[11], want[10:8], want[7:1], want[0]);
   endtask

   task automatic cycle(input logic r, input logic h, input logic [2:0] n);
      rst = r; hit = h; lineCount = n;
      @(posedge clk);
      model_step(r, h, int'(n));
      #1;
      for (int i = 0; i < 3; i++) check($sformatf("model_dut%0d", i), got(i), model_exp(i));
   endtask

   typedef struct {
      logic       r;
      logic       h;
      logic [2:0] n;
      logic       e_ht;
      logic       e_bl;
      logic [2:0] e_cl;
      int         e_rem;
      logic       e_dn;
   } vec_t;

   vec_t vt[20];

   initial begin
      // Default configuration: reset, ignored hit, n=1 window, then n=2 window with blink.
      vt[0]  = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 0, 1'b0};
      vt[1]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 0, 1'b0};
      vt[2]  = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 0, 1'b0};
      vt[3]  = '{1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 3'd1, 3, 1'b0};
      vt[4]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd1, 2, 1'b0};
      vt[5]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd1, 1, 1'b0};
      vt[6]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd1, 0, 1'b0};
      vt[7]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 0, 1'b1};
      vt[8]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 0, 1'b0};
      vt[9]  = '{1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 3'd1, 8, 1'b0};
      vt[10] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd1, 7, 1'b0};
      vt[11] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd1, 6, 1'b0};
      vt[12] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd1, 5, 1'b0};
      vt[13] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd1, 4, 1'b0};
      vt[14] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd1, 3, 1'b0};
      vt[15] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd1, 2, 1'b0};
      vt[16] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd1, 1, 1'b0};
      vt[17] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd1, 0, 1'b0};
      vt[18] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 0, 1'b1};
      vt[19] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 0, 1'b0};

      for (int i = 0; i < 20; i++) begin
         cycle(vt[i].r, vt[i].h, vt[i].n);
         check($sformatf("vec%0d", i), got(0),
               pack(vt[i].e_ht, vt[i].e_bl, vt[i].e_cl, 7'(vt[i].e_rem), vt[i].e_dn));
      end

      // Retrigger at remaining=10: restart reloads, extend keeps the longer window.
      cycle(1'b1, 1'b0, 3'd0);
      cycle(1'b0, 1'b1, 3'd3);
      repeat (5) cycle(1'b0, 1'b0, 3'd0);
      check("pre_retrig_rem", 13'(rem0), 13'd10);
      cycle(1'b0, 1'b1, 3'd1);
      check("restart_rem",   13'(rem0), 13'd3);
      check("restart_combo", 13'(cl0),  13'd2);
      check("extend_rem",    13'(rem1), 13'd10);
      check("extend_combo",  13'(cl1),  13'd2);

      // Narrow countdown saturates; zero-line hits are ignored.
      cycle(1'b1, 1'b0, 3'd0);
      cycle(1'b0, 1'b1, 3'd0);
      check("zero_line_idle", got(0), 13'd0);
      cycle(1'b0, 1'b1, 3'd4);
      check("sat_rem_tw4", 13'(rem2), 13'd15);
      check("rem_tw6_n4",  13'(rem0), 13'd24);
      cycle(1'b0, 1'b1, 3'd0);
      check("zero_line_active_rem",   13'(rem2), 13'd14);
      check("zero_line_active_combo", 13'(cl2),  13'd1);

      // Hit on the expiry edge, then reset with a hit mid-window.
      cycle(1'b1, 1'b0, 3'd0);
      cycle(1'b0, 1'b1, 3'd1);
      repeat (3) cycle(1'b0, 1'b0, 3'd0);
      check("at_zero_rem", 13'(rem0), 13'd0);
      cycle(1'b0, 1'b1, 3'd1);
      check("expiry_hit", got(0), pack(1'b1, 1'b1, 3'd2, 7'd3, 1'b0));
      cycle(1'b0, 1'b0, 3'd0);
      cycle(1'b1, 1'b1, 3'd5);
      check("rst_mid_dut0", got(0), 13'd0);
      check("rst_mid_dut1", got(1), 13'd0);
      check("rst_mid_dut2", got(2), 13'd0);
      cycle(1'b0, 1'b0, 3'd0);
      check("after_rst_no_done", got(0), 13'd0);

      // Combo saturation at 7.
      repeat (9) cycle(1'b0, 1'b1, 3'd1);
      check("combo_sat", 13'(cl0), 13'd7);

      // Random traffic.
      repeat (800) begin
         logic r, h;
         logic [2:0] n;
         r = ($urandom_range(0, 99) < 2);
         h = ($urandom_range(0, 99) < 15);
         n = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
         cycle(r, h, n);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
